// File: rtl/vx_dcache_responder_pkg.sv
// Shared types and width helpers for the dcache responder.
// Imported by the responder top and its lane picker.
package vx_dcache_responder_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_e;

  function automatic int word_width(input int ws);
    return 8 * ws;
  endfunction

  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int lane_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_lane_pick.sv
// Lowest-set-bit priority encoder over a lane mask.
// Gives one-hot, binary index and an any-set flag.
module vx_lane_pick
  import vx_dcache_responder_pkg::*;
#(
  parameter int N  = 4,
  parameter int LW = lane_width(N)
) (
  input  logic [N-1:0]  req_i,
  output logic [N-1:0]  onehot_o,
  output logic [LW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    // Descending scan so the lowest set lane wins.
    for (int i = N - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        onehot_o    = '0;
        onehot_o[i] = 1'b1;
        idx_o       = LW'(i);
        any_o       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vx_dcache_responder.sv
// Scratch-memory dcache responder: captures a lane bundle,
// serializes lanes onto one word array, returns one read beat.
module vx_dcache_responder
  import vx_dcache_responder_pkg::*;
#(
  parameter int NUM_REQS   = 4,
  parameter int WORD_SIZE  = 4,
  parameter int ADDR_WIDTH = 30,
  parameter int TAG_WIDTH  = 8,
  parameter int DEPTH      = 256
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_REQS-1:0]                  req_valid,
  input  logic [NUM_REQS-1:0]                  req_rw,
  input  logic [NUM_REQS*WORD_SIZE-1:0]        req_byteen,
  input  logic [NUM_REQS*ADDR_WIDTH-1:0]       req_addr,
  input  logic [NUM_REQS*8*WORD_SIZE-1:0]      req_data,
  input  logic [NUM_REQS*TAG_WIDTH-1:0]        req_tag,
  output logic [NUM_REQS-1:0]                  req_ready,
  output logic [NUM_REQS-1:0]                  rsp_valid,
  output logic [NUM_REQS*8*WORD_SIZE-1:0]      rsp_data,
  output logic [TAG_WIDTH-1:0]                 rsp_tag,
  input  logic                                 rsp_ready
);

  localparam int N  = NUM_REQS;
  localparam int WS = WORD_SIZE;
  localparam int AW = ADDR_WIDTH;
  localparam int TW = TAG_WIDTH;
  localparam int WW = word_width(WORD_SIZE);
  localparam int IW = idx_width(DEPTH);
  localparam int LW = lane_width(NUM_REQS);

  state_e state_q, state_d;

  logic [N-1:0]    pend_q, pend_d;
  logic [N-1:0]    rd_mask_q;
  logic [N-1:0]    rw_q;
  logic [N*WS-1:0] be_q;
  logic [N*IW-1:0] idx_q;
  logic [N*WW-1:0] wdata_q;
  logic [N*TW-1:0] tag_q;
  logic [N*WW-1:0] rdata_q;

  logic [WW-1:0] mem [DEPTH];

  logic          accept;
  logic          in_access;
  logic          in_respond;

  logic [N-1:0]  svc_oh;
  logic [LW-1:0] svc_idx;
  logic          svc_any;
  int            svc_l;
  logic          svc_rw;
  logic [WS-1:0] svc_be;
  logic [IW-1:0] svc_addr;
  logic [WW-1:0] svc_wdata;

  logic [LW-1:0] tag_idx;
  int            tag_l;
  logic [N-1:0]  unused_tag_oh;
  logic          unused_tag_any;
  logic          unused_addr;

  vx_lane_pick #(
    .N  (N),
    .LW (LW)
  ) u_svc_pick (
    .req_i    (pend_q),
    .onehot_o (svc_oh),
    .idx_o    (svc_idx),
    .any_o    (svc_any)
  );

  vx_lane_pick #(
    .N  (N),
    .LW (LW)
  ) u_tag_pick (
    .req_i    (rd_mask_q),
    .onehot_o (unused_tag_oh),
    .idx_o    (tag_idx),
    .any_o    (unused_tag_any)
  );

  // Upper address bits alias onto the array by design.
  assign unused_addr = ^req_addr;

  assign in_access  = (state_q == ACCESS);
  assign in_respond = (state_q == RESPOND) && reset;
  assign req_ready  = {N{(state_q == IDLE) && reset}};
  assign accept     = (state_q == IDLE) && |(req_valid & req_ready);

  assign svc_l     = 32'(svc_idx);
  assign svc_rw    = rw_q[svc_l];
  assign svc_be    = be_q[svc_l*WS +: WS];
  assign svc_addr  = idx_q[svc_l*IW +: IW];
  assign svc_wdata = wdata_q[svc_l*WW +: WW];

  assign tag_l     = 32'(tag_idx);
  assign rsp_valid = in_respond ? rd_mask_q : '0;
  assign rsp_tag   = in_respond ? tag_q[tag_l*TW +: TW] : '0;
  assign rsp_data  = rdata_q;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          pend_d  = req_valid;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        pend_d = pend_q & ~svc_oh;
        if (pend_d == '0) begin
          state_d = (rd_mask_q != '0) ? RESPOND : IDLE;
        end
      end
      RESPOND: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        pend_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_mask_q <= '0;
      rw_q      <= '0;
      be_q      <= '0;
      idx_q     <= '0;
      wdata_q   <= '0;
      tag_q     <= '0;
      rdata_q   <= '0;
    end else if (accept) begin
      rd_mask_q <= req_valid & ~req_rw;
      rw_q      <= req_rw;
      be_q      <= req_byteen;
      wdata_q   <= req_data;
      tag_q     <= req_tag;
      rdata_q   <= '0;
      for (int i = 0; i < N; i++) begin
        idx_q[i*IW +: IW] <= req_addr[i*AW +: IW];
      end
    end else if (in_access && svc_any && !svc_rw) begin
      // Earlier lanes' writes already landed on prior edges.
      rdata_q[svc_l*WW +: WW] <= mem[svc_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset && in_access && svc_any && svc_rw) begin
      for (int b = 0; b < WS; b++) begin
        if (svc_be[b]) begin
          mem[svc_addr][b*8 +: 8] <= svc_wdata[b*8 +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_vx_dcache_responder.sv
// Randomized bench for vx_dcache_responder against a
// sequential lane-order memory model.
module tb_vx_dcache_responder;

  localparam int N     = 4;
  localparam int WS    = 4;
  localparam int AW    = 30;
  localparam int TW    = 8;
  localparam int DW    = 32;
  localparam int DEPTH = 256;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_rw;
  logic [N*WS-1:0] req_byteen;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N*TW-1:0] req_tag;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [N*DW-1:0] rsp_data;
  logic [TW-1:0]   rsp_tag;
  logic            rsp_ready;

  vx_dcache_responder #(
    .NUM_REQS   (N),
    .WORD_SIZE  (WS),
    .ADDR_WIDTH (AW),
    .TAG_WIDTH  (TW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_rw     (req_rw),
    .req_byteen (req_byteen),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_tag    (req_tag),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_tag    (rsp_tag),
    .rsp_ready  (rsp_ready)
  );

  always #5 clk = ~clk;

  int npass = 0;
  int ntot  = 0;

  bit              chk = 1'b0;
  bit              noise = 1'b0;
  bit              exp_zero = 1'b0;
  logic [N-1:0]    exp_ready;
  logic [N-1:0]    exp_rvalid;
  logic [N*DW-1:0] exp_rdata;
  logic [TW-1:0]   exp_rtag;

  logic [DW-1:0]   mm [DEPTH];
  logic [N-1:0]    last_m;
  logic [N*DW-1:0] last_d;
  logic [TW-1:0]   last_t;

  task automatic check(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (chk) begin
      check("req_ready", 128'(req_ready), 128'(exp_ready));
      check("rsp_valid", 128'(rsp_valid), 128'(exp_rvalid));
      if (exp_rvalid != '0) begin
        check("rsp_data", rsp_data, exp_rdata);
        check("rsp_tag", 128'(rsp_tag), 128'(exp_rtag));
      end
      if (exp_zero) begin
        check("rst_data", rsp_data, 128'h0);
        check("rst_tag", 128'(rsp_tag), 128'h0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*AW-1:0] mk_addr(input int a0, a1, a2, a3);
    return {30'(a3), 30'(a2), 30'(a1), 30'(a0)};
  endfunction

  function automatic logic [N*AW-1:0] rnd_addr(input bit hazard);
    logic [N*AW-1:0] r;
    for (int i = 0; i < N; i++) begin
      r[i*AW +: AW] = 30'($urandom);
      if (hazard) r[i*AW +: 8] = 8'($urandom_range(0, 15));
    end
    return r;
  endfunction

  // Lanes run in ascending order against a word array.
  task automatic model(input logic [N-1:0] v, rw,
                       input logic [N*WS-1:0] be,
                       input logic [N*AW-1:0] a,
                       input logic [N*DW-1:0] d,
                       input logic [N*TW-1:0] t,
                       output logic [N-1:0] m,
                       output logic [N*DW-1:0] rd,
                       output logic [TW-1:0] tg);
    int ix;
    bit found;
    m = '0; rd = '0; tg = '0; found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        ix = int'(a[i*AW +: 8]);
        if (rw[i]) begin
          for (int b = 0; b < WS; b++)
            if (be[i*WS + b]) mm[ix][b*8 +: 8] = d[i*DW + b*8 +: 8];
        end else begin
          rd[i*DW +: DW] = mm[ix];
          m[i] = 1'b1;
          if (!found) tg = t[i*TW +: TW];
          found = 1'b1;
        end
      end
    end
  endtask

  task automatic drive_noise();
    if (noise) begin
      req_valid  = N'($urandom);
      req_rw     = N'($urandom);
      req_byteen = 16'($urandom);
      req_addr   = rnd_addr(1'b0);
      req_data   = {$urandom, $urandom, $urandom, $urandom};
      req_tag    = 32'($urandom);
      rsp_ready  = 1'($urandom);
    end else begin
      req_valid = '0;
    end
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      drive_noise();
      req_valid  = '0;
      exp_ready  = '1;
      exp_rvalid = '0;
      tick();
    end
  endtask

  task automatic send(input logic [N-1:0] v, rw,
                      input logic [N*WS-1:0] be,
                      input logic [N*AW-1:0] a,
                      input logic [N*DW-1:0] d,
                      input logic [N*TW-1:0] t,
                      input int hold, input bit rst_rsp);
    int k;
    req_valid  = v;
    req_rw     = rw;
    req_byteen = be;
    req_addr   = a;
    req_data   = d;
    req_tag    = t;
    exp_ready  = '1;
    exp_rvalid = '0;
    model(v, rw, be, a, d, t, last_m, last_d, last_t);
    k = $countones(v);
    tick();
    for (int c = 0; c < k; c++) begin
      drive_noise();
      exp_ready  = '0;
      exp_rvalid = '0;
      tick();
    end
    if (last_m != '0) begin
      exp_rvalid = last_m;
      exp_rdata  = last_d;
      exp_rtag   = last_t;
      if (rst_rsp) begin
        rsp_ready = 1'b0;
        tick();
        reset      = 1'b0;
        exp_rvalid = '0;
        tick();
        exp_zero = 1'b1;
        tick();
        tick();
        reset    = 1'b1;
        exp_zero = 1'b0;
      end else begin
        for (int h = 0; h < hold; h++) begin
          drive_noise();
          rsp_ready = 1'b0;
          tick();
        end
        drive_noise();
        rsp_ready = 1'b1;
        tick();
      end
    end
    drive_noise();
    req_valid  = '0;
    rsp_ready  = 1'b0;
    exp_ready  = '1;
    exp_rvalid = '0;
  endtask

  initial begin
    reset      = 1'b0;
    req_valid  = '0;
    req_rw     = '0;
    req_byteen = '0;
    req_addr   = '0;
    req_data   = '0;
    req_tag    = '0;
    rsp_ready  = 1'b0;
    exp_ready  = '0;
    exp_rvalid = '0;
    exp_rdata  = '0;
    exp_rtag   = '0;
    tick();
    chk      = 1'b1;
    exp_zero = 1'b1;
    tick();
    tick();
    reset    = 1'b1;
    exp_zero = 1'b0;
    exp_ready = '1;
    idle(1);

    for (int base = 0; base < DEPTH; base += 4)
      send(4'hF, 4'hF, '1, mk_addr(base, base + 1, base + 2, base + 3),
           '0, '0, 0, 1'b0);

    send(4'hF, 4'hF, '1, mk_addr(0, 1, 2, 3),
         {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111},
         '0, 0, 1'b0);
    check("pin_mm2", 128'(mm[2]), 128'h33333333);

    send(4'b1010, 4'b0000, '0, mk_addr(0, 1, 0, 3), '0,
         {8'h07, 8'h00, 8'h05, 8'h00}, 5, 1'b0);
    check("pin_rd_data", last_d,
          {32'h44444444, 32'h0, 32'h22222222, 32'h0});
    check("pin_rd_mask", 128'(last_m), 128'hA);
    check("pin_rd_tag", 128'(last_t), 128'h5);

    send(4'b0011, 4'b0001, 16'h0003, mk_addr(9, 9, 0, 0),
         {96'h0, 32'hDEADBEEF}, {8'h0, 8'h0, 8'h2A, 8'h1B}, 1, 1'b0);
    check("pin_mixed", 128'(last_d[63:32]), 128'h0000BEEF);
    check("pin_mixed_mask", 128'(last_m), 128'h2);

    send(4'b0001, 4'b0001, 16'h000F, mk_addr(32'h100, 0, 0, 0),
         {96'h0, 32'hCAFEF00D}, '0, 0, 1'b0);
    send(4'b0100, 4'b0000, '0, mk_addr(0, 0, 0, 0), '0,
         {8'h0, 8'h3C, 8'h0, 8'h0}, 0, 1'b0);
    check("pin_alias", 128'(last_d[95:64]), 128'hCAFEF00D);

    noise = 1'b1;
    for (int it = 0; it < 200; it++) begin
      if ($urandom_range(0, 7) == 0) begin
        idle($urandom_range(1, 3));
      end else begin
        send(N'($urandom_range(1, 15)), N'($urandom),
             16'($urandom), rnd_addr(1'b1),
             {$urandom, $urandom, $urandom, $urandom},
             32'($urandom), $urandom_range(0, 3),
             $urandom_range(0, 24) == 0);
      end
    end

    send(4'b0011, 4'b0001, 16'h00FF, mk_addr(20, 20, 0, 0),
         {64'h0, 32'h0, 32'h89ABCDEF}, {16'h0, 8'h44, 8'h33},
         0, 1'b1);
    idle(2);
    send(4'b1000, 4'b0000, '0, mk_addr(0, 0, 0, 20), '0,
         {8'h61, 24'h0}, 2, 1'b0);
    check("pin_post_rst", 128'(last_d[127:96]), 128'h89ABCDEF);

    chk = 1'b0;
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
